ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic.
- Directly upstream of the execute ALU; drives its src_A, src_B and ALU_Control.
- Captures decoded operands and control each cycle and resolves RAW hazards against the EX/MEM and MEM/WB stages.
- Inserts one bubble on a load-use hazard.

Parameters:
- WIDTH, 32, datapath width of operands, immediates and results
- REG_ADDR, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold the stage contents (downstream back-pressure)
- flush  in  1  replace the next captured entry with a bubble (branch redirect)
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2, id_rd  in  REG_ADDR  source and destination register indices
- id_rd1, id_rd2  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_alu_src  in  1  1 selects id_imm as operand B
- id_alu_ctrl  in  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- id_reg_write, id_mem_read, id_mem_write  in  1  each  control bits
- mem_rd  in  REG_ADDR  EX/MEM destination register
- mem_reg_write  in  1  EX/MEM write enable
- mem_alu_result  in  WIDTH  EX/MEM result
- wb_rd  in  REG_ADDR  MEM/WB destination register
- wb_reg_write  in  1  MEM/WB write enable
- wb_result  in  WIDTH  MEM/WB result
- ex_valid  out  1  stage holds a real instruction
- src_A, src_B  out  WIDTH  ALU operands
- ALU_Control  out  3  registered id_alu_ctrl
- ex_store_data  out  WIDTH  forwarded rs2 value, used as store data
- ex_rd  out  REG_ADDR  registered destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  each  registered control, gated by ex_valid
- load_use_stall  out  1  asks the IF/ID stages to hold for one cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered fields clear to 0, so ex_valid=0, ALU_Control=000, ex_rd=0, and all control bits are 0.
  - src_A, src_B and ex_store_data read 0 while reset is held.
- Update priority at each posedge clk: reset > flush > stall > load_use_stall > normal load.
  - flush: capture a bubble. valid=0, all control bits=0, ALU_Control=000, rd=0. Flush wins over stall when both are high.
  - stall (flush low): hold every register unchanged.
  - load_use_stall (stall and flush low): capture a bubble. The decode stage holds its instruction, so it is re-presented on the next cycle.
  - Normal: capture every id_* field. Captured valid = id_valid. Control bits are ANDed with id_valid.
- load_use_stall (combinational) = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Forwarding (combinational, from the registered rs1/rs2), operand A:
  - If mem_reg_write & mem_rd != 0 & mem_rd == rs1_q: use mem_alu_result.
  - Else if wb_reg_write & wb_rd != 0 & wb_rd == rs1_q: use wb_result.
  - Else: use rd1_q.
  - EX/MEM always takes priority over MEM/WB.
- Forwarding, operand B uses the same rule with rs2_q/rd2_q and produces fwd_B.
  - ex_store_data = fwd_B.
  - src_B = alu_src_q ? imm_q : fwd_B.
- Register x0 is never forwarded.
- Latency: one cycle from the id_* inputs to the ALU operands. Forwarding adds no cycles.
- After a bubble the operand outputs are don't-care, but ex_reg_write and ex_mem_write are guaranteed 0.
- rst_n deasserted in the middle of a stream resumes from the bubble state. No partial entry survives reset.

Optional Feature:
- Macro: EX_FORWARDING_EN.
- Defined: forwarding muxes present, as described in Behaviour.
- Not defined:
  - src_A = rd1_q; fwd_B = rd2_q; no forwarding logic.
  - load_use_stall widens to any RAW hazard: id_valid & (rs1 or rs2 nonzero and matching a writing, valid ex_rd, or a writing mem_rd).
  - Each matched hazard inserts bubbles until the writer has left MEM.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release with id_valid=1, id_alu_ctrl=001, id_rd1=9, id_rd2=4, no hazards -> next cycle ex_valid=1, src_A=9, src_B=4, ALU_Control=001.
- Immediate select: id_alu_src=1, id_imm=0xFFFFFFF0 -> src_B=0xFFFFFFF0 one cycle later, and ex_store_data still equals the rs2 path.
- Double-hazard priority: rs1_q=5 with mem_rd=5/mem_alu_result=0x11 and wb_rd=5/wb_result=0x22 -> src_A=0x11. With mem_reg_write=0 -> src_A=0x22. With rd=0 sources -> no forwarding.
- Load-use: load to x7 in EX, next decode reads rs2=7 -> load_use_stall=1 for exactly one cycle, one bubble (ex_valid=0, ex_reg_write=0), then the instruction enters with wb forwarding of the load value.
- stall=1 for 3 cycles with changing id_* -> outputs frozen. flush=1 together with stall=1 -> bubble captured on that edge.
- Build without EX_FORWARDING_EN: producer of x3 followed immediately by a consumer of x3 -> bubbles until the producer leaves MEM, then src_A = rd1 value supplied by the bench.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with operand forwarding and load-use detection.
// Optional macro EX_FORWARDING_EN enables the EX/MEM and MEM/WB bypass muxes.
module ex_operand_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_rs1,
    input  logic [REG_ADDR-1:0] id_rs2,
    input  logic [REG_ADDR-1:0] id_rd,
    input  logic [WIDTH-1:0]    id_rd1,
    input  logic [WIDTH-1:0]    id_rd2,
    input  logic [WIDTH-1:0]    id_imm,
    input  logic                id_alu_src,
    input  logic [2:0]          id_alu_ctrl,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic [REG_ADDR-1:0] mem_rd,
    input  logic                mem_reg_write,
    input  logic [WIDTH-1:0]    mem_alu_result,
    input  logic [REG_ADDR-1:0] wb_rd,
    input  logic                wb_reg_write,
    input  logic [WIDTH-1:0]    wb_result,
    output logic                ex_valid,
    output logic [WIDTH-1:0]    src_A,
    output logic [WIDTH-1:0]    src_B,
    output logic [2:0]          ALU_Control,
    output logic [WIDTH-1:0]    ex_store_data,
    output logic [REG_ADDR-1:0] ex_rd,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                load_use_stall
);

    logic                valid_q, valid_d;
    logic [REG_ADDR-1:0] rs1_q, rs1_d;
    logic [REG_ADDR-1:0] rs2_q, rs2_d;
    logic [REG_ADDR-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]    rd1_q, rd1_d;
    logic [WIDTH-1:0]    rd2_q, rd2_d;
    logic [WIDTH-1:0]    imm_q, imm_d;
    logic                alu_src_q, alu_src_d;
    logic [2:0]          alu_ctrl_q, alu_ctrl_d;
    logic                reg_write_q, reg_write_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [WIDTH-1:0]    fwd_A;
    logic [WIDTH-1:0]    fwd_B;

`ifdef EX_FORWARDING_EN
    // Bypass operands from EX/MEM first, then MEM/WB; x0 is never bypassed
    always_comb begin
        fwd_A = rd1_q;
        if (mem_reg_write && mem_rd != '0 && mem_rd == rs1_q)
            fwd_A = mem_alu_result;
        else if (wb_reg_write && wb_rd != '0 && wb_rd == rs1_q)
            fwd_A = wb_result;
        fwd_B = rd2_q;
        if (mem_reg_write && mem_rd != '0 && mem_rd == rs2_q)
            fwd_B = mem_alu_result;
        else if (wb_reg_write && wb_rd != '0 && wb_rd == rs2_q)
            fwd_B = wb_result;
    end

    // Only a load in EX cannot be bypassed in time
    always_comb begin
        load_use_stall = valid_q && mem_read_q && rd_q != '0 && id_valid &&
                         (rd_q == id_rs1 || rd_q == id_rs2);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{mem_alu_result, wb_rd, wb_reg_write, wb_result};

    // Without bypassing operands come straight from the register file
    always_comb begin
        fwd_A = rd1_q;
        fwd_B = rd2_q;
    end

    // Any RAW hazard against a writer still in EX or MEM holds decode
    always_comb begin
        load_use_stall = id_valid && (
            (id_rs1 != '0 &&
             ((valid_q && reg_write_q && rd_q == id_rs1) ||
              (mem_reg_write && mem_rd == id_rs1))) ||
            (id_rs2 != '0 &&
             ((valid_q && reg_write_q && rd_q == id_rs2) ||
              (mem_reg_write && mem_rd == id_rs2))));
    end
`endif

    // Next entry: flush bubble, stall hold, hazard bubble, else capture decode
    always_comb begin
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        imm_d       = imm_q;
        alu_src_d   = alu_src_q;
        alu_ctrl_d  = alu_ctrl_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (flush || (!stall && load_use_stall)) begin
            valid_d     = 1'b0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            rd1_d       = '0;
            rd2_d       = '0;
            imm_d       = '0;
            alu_src_d   = 1'b0;
            alu_ctrl_d  = 3'b000;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (!stall) begin
            valid_d     = id_valid;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            rd1_d       = id_rd1;
            rd2_d       = id_rd2;
            imm_d       = id_imm;
            alu_src_d   = id_alu_src;
            alu_ctrl_d  = id_alu_ctrl;
            reg_write_d = id_reg_write & id_valid;
            mem_read_d  = id_mem_read & id_valid;
            mem_write_d = id_mem_write & id_valid;
        end
    end

    // ID/EX pipeline register, cleared to a bubble on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            alu_ctrl_q  <= 3'b000;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            alu_src_q   <= alu_src_d;
            alu_ctrl_q  <= alu_ctrl_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Drive the ALU operands and gated control
    always_comb begin
        ex_valid      = valid_q;
        src_A         = fwd_A;
        src_B         = alu_src_q ? imm_q : fwd_B;
        ex_store_data = fwd_B;
        ALU_Control   = alu_ctrl_q;
        ex_rd         = rd_q;
        ex_reg_write  = reg_write_q & valid_q;
        ex_mem_read   = mem_read_q & valid_q;
        ex_mem_write  = mem_write_q & valid_q;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed and random checks of ex_operand_stage.
// Reference model tracks the held instruction; EX_FORWARDING_EN selects variant.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall, flush, id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic        id_alu_src;
    logic [2:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_alu_result, wb_result;
    logic        ex_valid;
    logic [31:0] src_A, src_B, ex_store_data;
    logic [2:0]  ALU_Control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        load_use_stall;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_alu_src(id_alu_src),
        .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_alu_result(mem_alu_result), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .src_A(src_A), .src_B(src_B),
        .ALU_Control(ALU_Control), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        v;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] rd1, rd2, imm;
        bit        asrc;
        bit [2:0]  ctl;
        bit        rw, mr, mw;
    } ent_t;

    ent_t m = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit raw(bit [4:0] r);
        return r != 0 && ((m.v && m.rw && m.rd == r) ||
                          (mem_reg_write && mem_rd == r));
    endfunction

    function automatic bit lu_exp();
`ifdef EX_FORWARDING_EN
        return m.v && m.mr && m.rd != 0 && id_valid &&
               (m.rd == id_rs1 || m.rd == id_rs2);
`else
        return id_valid && (raw(id_rs1) || raw(id_rs2));
`endif
    endfunction

    function automatic bit [31:0] pick(bit [4:0] r, bit [31:0] dflt);
`ifdef EX_FORWARDING_EN
        if (mem_reg_write && mem_rd != 0 && mem_rd == r) return mem_alu_result;
        if (wb_reg_write && wb_rd != 0 && wb_rd == r) return wb_result;
`endif
        return dflt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m = '0;
        else if (flush) m = '0;
        else if (stall) m = m;
        else if (lu_exp()) m = '0;
        else begin
            m.v = id_valid;
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm;
            m.asrc = id_alu_src; m.ctl = id_alu_ctrl;
            m.rw = id_reg_write & id_valid;
            m.mr = id_mem_read & id_valid;
            m.mw = id_mem_write & id_valid;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit [31:0] fb;
            fb = pick(m.rs2, m.rd2);
            chk("m_valid", ex_valid, m.v);
            chk("m_ctrl", ALU_Control, m.ctl);
            chk("m_rd", ex_rd, m.rd);
            chk("m_rw", ex_reg_write, m.rw);
            chk("m_mr", ex_mem_read, m.mr);
            chk("m_mw", ex_mem_write, m.mw);
            chk("m_lus", load_use_stall, lu_exp());
            if (m.v) begin
                chk("m_srcA", src_A, pick(m.rs1, m.rd1));
                chk("m_srcB", src_B, m.asrc ? m.imm : fb);
                chk("m_store", ex_store_data, fb);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; id_valid = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        id_alu_src = 0; id_alu_ctrl = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        mem_rd = 0; mem_reg_write = 0; mem_alu_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    task automatic rnd_id();
        bit [2:0] ops [5];
        ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        id_valid = ($urandom % 8) != 0;
        id_rs1 = 5'($urandom % 8);
        id_rs2 = 5'($urandom % 8);
        id_rd = 5'($urandom % 8);
        id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        id_alu_src = 1'($urandom);
        id_alu_ctrl = ops[$urandom % 5];
        id_reg_write = 1'($urandom);
        id_mem_read = 1'($urandom);
        id_mem_write = 1'($urandom);
        mem_rd = 5'($urandom % 8);
        mem_reg_write = 1'($urandom);
        mem_alu_result = $urandom;
        wb_rd = 5'($urandom % 8);
        wb_reg_write = 1'($urandom);
        wb_result = $urandom;
    endtask

    initial begin
        idle();
        #2 rst_n = 0;
        chk_en = 1;
        repeat (3) begin
            step(); rnd_id(); mem_reg_write = 0;
        end
        @(negedge clk);
        chk("rst_valid", ex_valid, 0);
        chk("rst_srcA", src_A, 0);
        chk("rst_srcB", src_B, 0);
        chk("rst_store", ex_store_data, 0);
        chk("rst_ctrl", ALU_Control, 0);
        chk("rst_rd", ex_rd, 0);
        chk("rst_ctl", {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        chk("rst_lus", load_use_stall, 0);

        step(); idle(); rst_n = 1;
        id_valid = 1; id_alu_ctrl = 3'b001; id_rd1 = 9; id_rd2 = 4;
        id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_reg_write = 1;
        step(); idle();
        id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFF0;
        id_rd2 = 32'h55; id_rs1 = 1; id_rs2 = 2;
        @(negedge clk);
        chk("rel_valid", ex_valid, 1);
        chk("rel_srcA", src_A, 9);
        chk("rel_srcB", src_B, 4);
        chk("rel_ctrl", ALU_Control, 3'b001);
        step(); idle();
        @(negedge clk);
        chk("imm_srcB", src_B, 32'hFFFF_FFF0);
        chk("imm_store", ex_store_data, 32'h55);

        step(); idle(); id_valid = 1; id_rs1 = 5; id_rd1 = 32'h99;
        step(); idle(); stall = 1;
        mem_rd = 5; mem_reg_write = 1; mem_alu_result = 32'h11;
        wb_rd = 5; wb_reg_write = 1; wb_result = 32'h22;
        @(negedge clk);
`ifdef EX_FORWARDING_EN
        chk("dh_mem", src_A, 32'h11);
`else
        chk("dh_mem", src_A, 32'h99);
`endif
        mem_reg_write = 0;
        #1;
`ifdef EX_FORWARDING_EN
        chk("dh_wb", src_A, 32'h22);
`else
        chk("dh_wb", src_A, 32'h99);
`endif
        step(); idle(); id_valid = 1; id_rs1 = 0; id_rd1 = 32'h33;
        step(); idle();
        mem_rd = 0; mem_reg_write = 1; mem_alu_result = 32'h11;
        wb_rd = 0; wb_reg_write = 1; wb_result = 32'h22;
        @(negedge clk);
        chk("x0_srcA", src_A, 32'h33);

`ifdef EX_FORWARDING_EN
        step(); idle(); id_valid = 1; id_rd = 7;
        id_mem_read = 1; id_reg_write = 1; id_rs1 = 1;
        step(); idle(); id_valid = 1; id_rs1 = 1; id_rs2 = 7;
        id_rd1 = 32'h10; id_rd2 = 32'hBAD; id_rd = 8; id_reg_write = 1;
        @(negedge clk);
        chk("lu_stall", load_use_stall, 1);
        step(); mem_rd = 7; mem_reg_write = 1; mem_alu_result = 32'h1000;
        @(negedge clk);
        chk("lu_bub_v", ex_valid, 0);
        chk("lu_bub_rw", ex_reg_write, 0);
        chk("lu_once", load_use_stall, 0);
        step(); mem_reg_write = 0; mem_rd = 0; id_valid = 0;
        wb_rd = 7; wb_reg_write = 1; wb_result = 32'h77;
        @(negedge clk);
        chk("lu_valid", ex_valid, 1);
        chk("lu_srcA", src_A, 32'h10);
        chk("lu_srcB", src_B, 32'h77);
        chk("lu_store", ex_store_data, 32'h77);
`else
        step(); idle(); id_valid = 1; id_rd = 3;
        id_reg_write = 1; id_rs1 = 1; id_rd1 = 5;
        step(); idle(); id_valid = 1; id_rs1 = 3;
        id_rd1 = 32'hDEAD; id_rd = 9; id_reg_write = 1;
        @(negedge clk);
        chk("nf_lus_ex", load_use_stall, 1);
        step(); mem_rd = 3; mem_reg_write = 1;
        @(negedge clk);
        chk("nf_bub1", ex_valid, 0);
        chk("nf_lus_mem", load_use_stall, 1);
        step(); mem_reg_write = 0; mem_rd = 0;
        wb_rd = 3; wb_reg_write = 1; id_rd1 = 32'h3333;
        @(negedge clk);
        chk("nf_bub2", ex_valid, 0);
        chk("nf_lus_wb", load_use_stall, 0);
        step(); idle();
        @(negedge clk);
        chk("nf_valid", ex_valid, 1);
        chk("nf_srcA", src_A, 32'h3333);
        chk("nf_rd", ex_rd, 9);
`endif

        step(); idle(); id_valid = 1; id_rs1 = 2; id_rd1 = 32'hA1;
        id_alu_ctrl = 3'b010; id_rd = 4; id_reg_write = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            rnd_id(); stall = 1;
            mem_reg_write = 0; wb_reg_write = 0;
            @(negedge clk);
            chk("st_valid", ex_valid, 1);
            chk("st_srcA", src_A, 32'hA1);
            chk("st_ctrl", ALU_Control, 3'b010);
            chk("st_rd", ex_rd, 4);
            step();
        end
        flush = 1; stall = 1;
        step(); idle();
        @(negedge clk);
        chk("fl_valid", ex_valid, 0);
        chk("fl_rw", ex_reg_write, 0);
        chk("fl_ctrl", ALU_Control, 0);
        chk("fl_rd", ex_rd, 0);

        for (int i = 0; i < 3000; i++) begin
            rnd_id();
            stall = ($urandom % 10) == 0;
            flush = ($urandom % 20) == 0;
            rst_n = ($urandom % 100) != 0;
            step();
        end
        idle(); rst_n = 1;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
